// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state and grant encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  // Winner selection: DM priority, or alternate on contention when rr is set.
  function automatic gnt_t pick_grant(input logic if_req, input logic dm_req,
                                      input gnt_t last, input logic rr);
    gnt_t g;
    g = GNT_IF;
    if (if_req && dm_req) begin
      if (rr) g = (last == GNT_DM) ? GNT_IF : GNT_DM;
      else    g = GNT_DM;
    end else if (dm_req) begin
      g = GNT_DM;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single shared memory request/ack bus.
// Optional round-robin on contention: define MEM_ARB_RR_EN (default is fixed DM priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W/8-1:0] dm_we,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_ready,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall
);

  localparam int BE_W = DATA_W / 8;

`ifdef MEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  state_t              state_q;
  gnt_t                gnt_q;
  gnt_t                gnt_d;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [BE_W-1:0]     mem_we_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                if_ready_q;
  logic                dm_ready_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;

  always_comb begin
    gnt_d = pick_grant(if_req, dm_req, gnt_q, RR_EN);
  end

  // Ready is set on the ack edge so it is high during the single RESP cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if_ready_q <= 1'b0;
          dm_ready_q <= 1'b0;
          if (if_req || dm_req) begin
            gnt_q     <= gnt_d;
            mem_req_q <= 1'b1;
            state_q   <= BUSY;
            if (gnt_d == GNT_DM) begin
              mem_addr_q  <= dm_addr;
              mem_we_q    <= dm_we;
              mem_wdata_q <= dm_wdata;
            end else begin
              mem_addr_q  <= if_addr;
              mem_we_q    <= '0;
              mem_wdata_q <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (gnt_q == GNT_DM) begin
              dm_rdata_q <= mem_rdata;
              dm_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= mem_rdata;
              if_ready_q <= 1'b1;
            end
          end
        end
        RESP: begin
          if_ready_q <= 1'b0;
          dm_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          if_ready_q <= 1'b0;
          dm_ready_q <= 1'b0;
          mem_req_q  <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign stall     = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all ports.
REQ-002 Parameter DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 if_req  in  1  fetch request; held with if_addr stable until if_ready.
REQ-006 if_addr  in  ADDR_W  fetch address.
REQ-007 if_ready  out  1  one-cycle pulse; if_rdata valid this cycle.
REQ-008 if_rdata  out  DATA_W  fetched word, registered, held until next fetch completes.
REQ-009 dm_req  in  1  data request; held with addr/we/wdata stable until dm_ready.
REQ-010 dm_addr  in  ADDR_W  data address.
REQ-011 dm_we  in  DATA_W/8  byte write enables; all-zero means read.
REQ-012 dm_wdata  in  DATA_W  store data.
REQ-013 dm_ready  out  1  one-cycle completion pulse; dm_rdata valid this cycle.
REQ-014 dm_rdata  out  DATA_W  load data, registered, held until next data access completes.
REQ-015 mem_req  out  1  request to shared memory; held until mem_ack.
REQ-016 mem_addr / mem_we / mem_wdata  out  ADDR_W / DATA_W/8 / DATA_W  registered command of the granted requester; mem_we forced to zero for fetch grants.
REQ-017 mem_ack  in  1  memory completion; mem_rdata valid same cycle.
REQ-018 mem_rdata  in  DATA_W  memory read data.
REQ-019 stall  out  1  combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready).

Function
REQ-020 FSM states IDLE, BUSY, RESP; grant register gnt ∈ {IF, DM}.
REQ-021 IDLE: if any req, select winner, latch its addr/we/wdata into mem_* regs, set mem_req, go BUSY next cycle; else stay IDLE.
REQ-022 Arbitration: dm_req wins over if_req when both are asserted (default build).
REQ-023 BUSY: mem_req=1, command stable; on mem_ack, capture mem_rdata into the granted rdata register, drop mem_req, go RESP.
REQ-024 RESP: exactly one cycle; pulse granted ready (if_ready or dm_ready, never both); go IDLE.
REQ-025 Latency: req sampled in cycle 0, mem_req high from cycle 1, ack in cycle k≥1, ready in cycle k+1; minimum 3-cycle turnaround between consecutive grants.
REQ-026 mem_ack in IDLE or RESP is ignored; no state or data change.
REQ-027 A request dropped while BUSY still completes; its ready pulse is still generated.
REQ-028 Write grants (dm_we≠0) also load dm_rdata from mem_rdata; the value is don't-care to the requester.
REQ-029 Non-granted rdata register is unchanged by any access.

Reset
REQ-030 rst_n low at a clock edge: state→IDLE, mem_req=0, mem_addr/mem_we/mem_wdata=0, if_ready=dm_ready=0, if_rdata=dm_rdata=0, gnt=IF.
REQ-031 Reset mid-BUSY abandons the access; a mem_ack arriving afterwards is ignored per REQ-026.

Configuration
REQ-032 Macro MEM_ARB_RR_EN defined: on contention, grant goes to the requester not granted last (gnt toggles); an uncontested request is granted regardless of gnt.
REQ-033 Macro MEM_ARB_RR_EN undefined: fixed DM priority per REQ-022; gnt is still recorded.

Structure
REQ-034 Shared package mem_arb_pkg holds the state enum (IDLE, BUSY, RESP) and the grant encoding (GNT_IF=0, GNT_DM=1).
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 Single fetch: if_req, if_addr=0x100, ack 2 cycles after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0; if_ready pulses one cycle later with if_rdata=0xDEADBEEF.
REQ-037 Contention, default build: if_req and dm_req rise together, dm_we=4'hF, dm_addr=0x200 -> DM served first (mem_we=4'hF, mem_wdata=dm_wdata), then IF; dm_ready precedes if_ready.
REQ-038 Contention with MEM_ARB_RR_EN, both held for 4 grants -> grant order DM, IF, DM, IF.
REQ-039 Reset while BUSY, then mem_ack the next cycle -> mem_req=0, no ready pulse, state IDLE.
REQ-040 Spurious mem_ack in IDLE with no req -> no ready pulse, rdata registers unchanged.
REQ-041 Zero-wait memory (ack in first mem_req cycle) with dm_req held high -> dm_ready every 3rd cycle; stall=1 on the two cycles between pulses.
